uart_volt_rx: RTL and testbench



---
 rtl/uart_volt_rx_pkg.sv | 46 ++++
 rtl/uart_volt_rx_if.sv | 11 +
 rtl/uart_volt_rx_byte.sv | 109 ++++++++++
 rtl/uart_volt_rx.sv | 99 +++++++++
 tb/tb_uart_volt_rx.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/uart_volt_rx_pkg.sv
// Shared definitions for the voltage telemetry receiver: ASCII codes,
// parser state encodings, the packed voltage word and the oversample divisor.
package uart_defs;

   localparam logic [7:0] CH_A     = 8'd65;
   localparam logic [7:0] CH_D     = 8'd68;
   localparam logic [7:0] CH_1     = 8'd49;
   localparam logic [7:0] CH_COLON = 8'd58;
   localparam logic [7:0] CH_DOT   = 8'd46;
   localparam logic [7:0] CH_V     = 8'd86;
   localparam logic [7:0] CH_LF    = 8'd10;
   localparam logic [7:0] CH_CR    = 8'd13;
   localparam logic [7:0] CH_0     = 8'd48;
   localparam logic [7:0] CH_9     = 8'd57;

   localparam logic [3:0] P_H0   = 4'd0;
   localparam logic [3:0] P_H1   = 4'd1;
   localparam logic [3:0] P_H2   = 4'd2;
   localparam logic [3:0] P_H3   = 4'd3;
   localparam logic [3:0] P_SIGN = 4'd4;
   localparam logic [3:0] P_INT  = 4'd5;
   localparam logic [3:0] P_DOT  = 4'd6;
   localparam logic [3:0] P_F1   = 4'd7;
   localparam logic [3:0] P_F2   = 4'd8;
   localparam logic [3:0] P_F3   = 4'd9;
   localparam logic [3:0] P_UNIT = 4'd10;
   localparam logic [3:0] P_LF   = 4'd11;
   localparam logic [3:0] P_CR   = 4'd12;

   typedef struct packed {
      logic [7:0] sign;
      logic [3:0] zero;
      logic [3:0] int_d;
      logic [3:0] frac1;
      logic [3:0] frac2;
      logic [3:0] frac3;
   } volt_t;

   // Clocks per 1/16 bit, never below 1 so tiny ratios still run.
   function automatic int calc_div(input int clk_hz, input int baud);
      int d;
      d = clk_hz / (baud * 16);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_volt_rx_if.sv
// Serial input and decoded-word outputs of the telemetry receiver.
interface uart_volt_rx_if;
   logic        rx;
   logic [27:0] rdata;
   logic        valid;
   logic        frame_err;
   logic        parse_err;

   modport master (output rx, input rdata, valid, frame_err, parse_err);
   modport slave  (input rx, output rdata, valid, frame_err, parse_err);
endinterface

// File: rtl/uart_volt_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, 16x tick generator and bit FSM.
// byte_rdy/frame_err are one-cycle pulses registered at the stop-bit mid-sample.
module uart_rx_byte
   import uart_defs::*;
#(
   parameter int DIV = 325
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       byte_rdy,
   output logic       frame_err
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   logic          rx_s1, rx_s2, rx_last;
   logic [DW-1:0] div_cnt;
   logic          tick16;
   logic [2:0]    state;
   logic [3:0]    tick_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          fall;
   logic          mid;

   assign tick16 = (div_cnt == DW'(DIV - 1));
   assign fall   = rx_last & ~rx_s2;
   // tick_cnt runs modulo 16, so mid-bit recurs every 16 ticks after the start sample.
   assign mid    = tick16 && (tick_cnt == 4'd7);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_last <= 1'b1;
         div_cnt <= '0;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_last <= rx_s2;
         div_cnt <= tick16 ? '0 : div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         tick_cnt  <= 4'd0;
         bit_cnt   <= 3'd0;
         shift     <= 8'd0;
         rx_data   <= 8'd0;
         byte_rdy  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         byte_rdy  <= 1'b0;
         frame_err <= 1'b0;
         if (state != ST_IDLE && tick16)
            tick_cnt <= tick_cnt + 4'd1;
         case (state)
            ST_IDLE: begin
               if (fall) begin
                  state    <= ST_START;
                  tick_cnt <= 4'd0;
               end
            end
            ST_START: begin
               if (mid) begin
                  state   <= rx_s2 ? ST_IDLE : ST_DATA;
                  bit_cnt <= 3'd0;
               end
            end
            ST_DATA: begin
               if (mid) begin
                  shift   <= {rx_s2, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (mid) begin
                  if (rx_s2) begin
                     rx_data  <= shift;
                     byte_rdy <= 1'b1;
                     state    <= ST_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               if (rx_s2)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_volt_rx.sv
// Telemetry line parser: turns "AD1:<s><d>.<ddd>V" LF CR into the packed voltage word.
// Outputs update one cycle after each received byte; valid/frame_err/parse_err are 1-cycle strobes.
module uart_volt_rx
   import uart_defs::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 9600
) (
   input  logic          clk50,
   input  logic          reset,
   uart_volt_rx_if.slave bus
);

   localparam int DIV = calc_div(CLK_HZ, BAUD);

   logic [7:0] rx_data;
   logic       byte_rdy;
   logic       byte_ferr;
   logic [3:0] pstate;
   volt_t      shadow;
   volt_t      rdata_q;
   logic       valid_q, ferr_q, perr_q;
   logic       is_digit;
   logic [3:0] digit;
   logic       byte_ok;

   uart_rx_byte #(.DIV(DIV)) u_byte (
      .clk       (clk50),
      .rst       (reset),
      .rx        (bus.rx),
      .rx_data   (rx_data),
      .byte_rdy  (byte_rdy),
      .frame_err (byte_ferr)
   );

   assign is_digit = (rx_data >= CH_0) && (rx_data <= CH_9);
   assign digit    = 4'(rx_data - CH_0);

   always_comb begin
      byte_ok = 1'b0;
      case (pstate)
         P_H0:   byte_ok = (rx_data == CH_A);
         P_H1:   byte_ok = (rx_data == CH_D);
         P_H2:   byte_ok = (rx_data == CH_1);
         P_H3:   byte_ok = (rx_data == CH_COLON);
         P_SIGN: byte_ok = 1'b1;
         P_INT, P_F1, P_F2, P_F3: byte_ok = is_digit;
         P_DOT:  byte_ok = (rx_data == CH_DOT);
         P_UNIT: byte_ok = (rx_data == CH_V);
         P_LF:   byte_ok = (rx_data == CH_LF);
         P_CR:   byte_ok = (rx_data == CH_CR);
         default: byte_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         pstate  <= P_H0;
         shadow  <= '0;
         rdata_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= byte_ferr;
         if (byte_ferr) begin
            pstate <= P_H0;
         end else if (byte_rdy) begin
            if (byte_ok) begin
               case (pstate)
                  P_SIGN: shadow.sign  <= rx_data;
                  P_INT:  shadow.int_d <= digit;
                  P_F1:   shadow.frac1 <= digit;
                  P_F2:   shadow.frac2 <= digit;
                  P_F3:   shadow.frac3 <= digit;
                  P_CR: begin
                     rdata_q <= shadow;
                     valid_q <= 1'b1;
                  end
                  default: ;
               endcase
               pstate <= (pstate == P_CR) ? P_H0 : pstate + 4'd1;
            end else begin
               // A stray 'A' may be the start of the next line, so keep it as the header's first byte.
               perr_q <= 1'b1;
               pstate <= (rx_data == CH_A) ? P_H1 : P_H0;
            end
         end
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.parse_err = perr_q;

endmodule

// File: tb/tb_uart_volt_rx.sv
// Directed and randomized line traffic against a template-matching reference model.
module tb_uart_volt_rx;

   localparam int CLK_HZ = 320;
   localparam int BAUD   = 10;
   localparam int BIT    = 32;            // 16 * (320 / (10*16))
   localparam logic [7:0] ANY = 8'h00;    // template marker: any byte
   localparam logic [7:0] DIG = 8'h01;    // template marker: ASCII digit

   logic clk50 = 1'b0;
   logic reset = 1'b1;
   always #5 clk50 = ~clk50;

   uart_volt_rx_if ifc ();

   uart_volt_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .clk50 (clk50),
      .reset (reset),
      .bus   (ifc)
   );

   int checks = 0;
   int fails  = 0;

   int n_valid = 0, n_perr = 0, n_ferr = 0, n_both = 0;
   always @(negedge clk50) begin
      if (ifc.valid)     n_valid++;
      if (ifc.parse_err) n_perr++;
      if (ifc.frame_err) n_ferr++;
      if (ifc.parse_err && ifc.frame_err) n_both++;
   end

   // Reference model: position within the line template.
   logic [7:0]  tmpl [13] = '{"A", "D", "1", ":", ANY, DIG, ".", DIG, DIG, DIG, "V", 8'd10, 8'd13};
   logic [7:0]  m_buf [13];
   int          m_pos = 0;
   int          e_valid = 0, e_perr = 0, e_ferr = 0;
   logic [27:0] e_rdata = '0;

   function automatic bit fits(input int pos, input logic [7:0] b);
      if (tmpl[pos] == ANY) return 1'b1;
      if (tmpl[pos] == DIG) return (b >= "0") && (b <= "9");
      return b == tmpl[pos];
   endfunction

   task automatic model_feed(input logic [7:0] b);
      if (fits(m_pos, b)) begin
         m_buf[m_pos] = b;
         m_pos++;
         if (m_pos == 13) begin
            e_rdata = {m_buf[4], 4'h0, 4'(m_buf[5] - 8'd48), 4'(m_buf[7] - 8'd48),
                       4'(m_buf[8] - 8'd48), 4'(m_buf[9] - 8'd48)};
            e_valid++;
            m_pos = 0;
         end
      end else begin
         e_perr++;
         m_pos = (b == "A") ? 1 : 0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input int n);
      ifc.rx = v;
      repeat (n) @(negedge clk50);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      drive(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive(b[i], BIT);
      drive(stop_bit, BIT);
   endtask

   task automatic tx(input logic [7:0] b);
      send_byte(b, 1'b1);
      model_feed(b);
   endtask

   task automatic tx_str(input string s);
      for (int i = 0; i < s.len(); i++) tx(s[i]);
   endtask

   task automatic tx_term();
      tx(8'd10);
      tx(8'd13);
   endtask

   // Well-formed line with random sign and digits; corrupt_pos >= 0 overwrites one byte.
   task automatic tx_rand_line(input int corrupt_pos);
      logic [7:0] ln [13];
      for (int i = 0; i < 13; i++) begin
         if (tmpl[i] == ANY)      ln[i] = 8'($urandom_range(32, 126));
         else if (tmpl[i] == DIG) ln[i] = 8'($urandom_range(48, 57));
         else                     ln[i] = tmpl[i];
      end
      if (corrupt_pos >= 0) ln[corrupt_pos] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 13; i++) tx(ln[i]);
   endtask

   task automatic check_all(input string tag);
      drive(1'b1, 2 * BIT);
      check({tag, ":valid_cnt"}, n_valid, e_valid);
      check({tag, ":perr_cnt"},  n_perr,  e_perr);
      check({tag, ":ferr_cnt"},  n_ferr,  e_ferr);
      check({tag, ":rdata"},     ifc.rdata, e_rdata);
      check({tag, ":overlap"},   n_both, 0);
   endtask

   initial begin
      ifc.rx = 1'b1;
      repeat (5) @(negedge clk50);
      check("rst:rdata", ifc.rdata, 0);
      check("rst:valid", ifc.valid, 0);
      check("rst:ferr",  ifc.frame_err, 0);
      check("rst:perr",  ifc.parse_err, 0);
      reset = 1'b0;
      drive(1'b1, 2 * BIT);

      tx_str("AD1:+3.141V"); tx_term();
      check_all("good");
      check("good:literal", ifc.rdata, 28'h2B03141);

      tx_str("AD1:+3.1x1V"); tx_term();
      check_all("bad_digit");
      tx_rand_line(-1);
      check_all("after_bad_digit");

      tx_str("AD");
      send_byte(8'h55, 1'b0);
      e_ferr++;
      m_pos = 0;
      drive(1'b0, 3 * BIT);
      drive(1'b1, BIT);
      check_all("frame");
      tx_rand_line(-1);
      check_all("after_frame");

      drive(1'b0, BIT / 4);
      drive(1'b1, 2 * BIT);
      check_all("glitch");
      tx_rand_line(-1);
      check_all("after_glitch");

      tx_str("ADAD1:-0.500V"); tx_term();
      check_all("resync");
      check("resync:literal", ifc.rdata, 28'h2D00500);

      tx_str("AD1:+3.1");
      drive(1'b1, BIT);
      #1 reset = 1'b1;
      #1;
      check("async_rst:rdata", ifc.rdata, 0);
      check("async_rst:valid", ifc.valid, 0);
      m_pos = 0;
      e_rdata = '0;
      repeat (3) @(negedge clk50);
      reset = 1'b0;
      drive(1'b1, BIT);
      tx_str("41V"); tx_term();
      check_all("after_reset_tail");
      tx_rand_line(-1);
      check_all("after_reset_line");

      for (int n = 0; n < 4; n++) begin
         tx_rand_line(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : -1);
         check_all("random");
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
